// File: rtl/blinky_timer.sv
// blinky_timer: reloadable down-counter that flags the cycle in which it reaches zero.
// The expire flag is decoded from the count register, so it is high for exactly one cycle per reload.
`timescale 1us/1ns
module blinky_timer #(
  parameter int unsigned ResetValue   = 100,
  parameter int unsigned CounterWidth = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic expire_o
);

  localparam logic [CounterWidth-1:0] Reload = CounterWidth'(ResetValue);
  localparam logic [CounterWidth-1:0] One    = CounterWidth'(1);

  logic [CounterWidth-1:0] r_cnt;

  assign expire_o = (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= Reload;
    end else if (expire_o) begin
      r_cnt <= Reload;
    end else begin
      r_cnt <= r_cnt - One;
    end
  end

endmodule

// File: rtl/blinky.sv
// blinky: free-running heartbeat LED, 50% duty square wave.
// The LED toggles once per timer expiry, giving a half-period of ResetValue+1 clk_i cycles.
`timescale 1us/1ns
module blinky #(
  parameter int unsigned ResetValue = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic led_o
);

  // A zero reload still needs one counter bit.
  localparam int unsigned CounterWidth = (ResetValue == 0) ? 1 : $clog2(ResetValue + 1);

  logic w_expire;
  logic r_led;

  blinky_timer #(
    .ResetValue  (ResetValue),
    .CounterWidth(CounterWidth)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .expire_o(w_expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_led <= 1'b0;
    end else if (w_expire) begin
      r_led <= ~r_led;
    end
  end

  assign led_o = r_led;

endmodule

// File: tb/tb_blinky.sv
// tb_blinky: randomized reset/run sequences on three blinky instances (ResetValue 100, 0, 1),
// compared every cycle against an arithmetic model of the LED waveform.
`timescale 1us/1ns
module tb_blinky;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  logic led_100, led_0, led_1;

  int n_checks = 0;
  int n_errors = 0;

  // Edge bookkeeping since the last reset release.
  int unsigned edges;
  int unsigned last_toggle;
  logic        prev_led;

  always #2500 clk_i = ~clk_i;  // 5 ms period

  blinky #(.ResetValue(100)) u_dut_100 (.clk_i(clk_i), .rst_ni(rst_ni), .led_o(led_100));
  blinky #(.ResetValue(0))   u_dut_0   (.clk_i(clk_i), .rst_ni(rst_ni), .led_o(led_0));
  blinky #(.ResetValue(1))   u_dut_1   (.clk_i(clk_i), .rst_ni(rst_ni), .led_o(led_1));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0d (%b), expected %0d at t=%0t", tag, observed, observed[0],
               expected, $time);
    end
  endtask

  // LED level after n edges since release: it flips once every rv+1 edges, starting low.
  function automatic logic model_led(input int unsigned n, input int unsigned rv);
    return ((n / (rv + 1)) % 2) == 1;
  endfunction

  task automatic release_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    edges       = 0;
    last_toggle = 0;
    prev_led    = 1'b0;
  endtask

  task automatic run_edges(input int unsigned n_edges);
    for (int i = 0; i < int'(n_edges); i++) begin
      @(posedge clk_i);
      edges++;
      @(negedge clk_i);
      check("led_rv100", {31'd0, led_100}, {31'd0, model_led(edges, 100)});
      check("led_rv0",   {31'd0, led_0},   {31'd0, model_led(edges, 0)});
      check("led_rv1",   {31'd0, led_1},   {31'd0, model_led(edges, 1)});
      if (led_100 !== prev_led) begin
        $info("led_o -> %b at edge %0d", led_100, edges);
        check("half_period_rv100", edges - last_toggle, 32'd101);
        last_toggle = edges;
        prev_led    = led_100;
      end
    end
  endtask

  task automatic assert_reset(input int unsigned hold_cycles);
    @(negedge clk_i);
    #($urandom_range(100, 2000));
    rst_ni = 1'b0;
    #1;
    check("async_reset_rv100", {31'd0, led_100}, 32'd0);
    check("async_reset_rv0",   {31'd0, led_0},   32'd0);
    check("async_reset_rv1",   {31'd0, led_1},   32'd0);
    for (int i = 0; i < int'(hold_cycles); i++) begin
      @(negedge clk_i);
      check("reset_hold_rv100", {31'd0, led_100}, 32'd0);
      check("reset_hold_rv0",   {31'd0, led_0},   32'd0);
      check("reset_hold_rv1",   {31'd0, led_1},   32'd0);
    end
  endtask

  initial begin
    // Reset from power-up (state unknown), held three cycles.
    assert_reset(3);
    release_reset();
    // Seven rises/falls plus 40 edges into a high phase, then reset mid-high.
    run_edges(101 * 7 + 40);
    check("mid_high_before_reset", {31'd0, led_100}, 32'd1);
    assert_reset(2);
    release_reset();
    run_edges(250);
    // Random run lengths and reset points.
    for (int seg = 0; seg < 6; seg++) begin
      assert_reset($urandom_range(1, 4));
      release_reset();
      run_edges($urandom_range(1, 400));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
